// File: rtl/dmem_responder.sv
// Word-organised data RAM answering MEM-stage load/store requests.
// Ports: clk, CLR (async active-low reset); request req/we/addr/wdata/Byte/Half/UnsignedExt;
//        response ready (1-cycle strobe), rdata (extended load data), busy, err (misaligned).
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        Byte,
    input  logic        Half,
    input  logic        UnsignedExt,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              byte_q;
    logic              half_q;
    logic              uns_q;

    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**ADDR_W];

    logic accept;
    logic enter_resp;

    // Upper address bits are ignored so accesses wrap modulo the RAM size.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = WAIT_INIT;
                    state_d = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------
    always_comb begin
        ready = (state_q == S_RESP);
        busy  = (state_q == S_WAIT);
        err   = err_q;
        rdata = rdata_q;
    end

    assign accept     = (state_q == S_IDLE) && req;
    // The edge that moves the FSM into RESP commits stores and registers
    // the response; with no wait states that is the accepting edge itself.
    assign enter_resp = (accept && NO_WAIT)
                     || ((state_q == S_WAIT) && (cnt_q == 4'd1));

    // ------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            uns_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            byte_q  <= Byte;
            half_q  <= Half;
            uns_q   <= UnsignedExt;
        end
    end

    // ------------------------------------------------------------
    // Operand select: live inputs on the accepting edge, captured
    // copies while waiting.
    // ------------------------------------------------------------
    logic              live;
    logic              op_we;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              op_byte;
    logic              op_half;
    logic              op_uns;

    assign live     = (state_q == S_IDLE);
    assign op_we    = live ? we                : we_q;
    assign op_addr  = live ? addr[ADDR_W+1:0]  : addr_q;
    assign op_wdata = live ? wdata             : wdata_q;
    assign op_byte  = live ? Byte              : byte_q;
    assign op_half  = live ? Half              : half_q;
    assign op_uns   = live ? UnsignedExt       : uns_q;

    logic [1:0]        lane;
    logic [ADDR_W-1:0] idx;
    logic              sz_byte, sz_half, sz_word;

    assign lane    = op_addr[1:0];
    assign idx     = op_addr[ADDR_W+1:2];
    // Byte wins over Half when both are set.
    assign sz_byte = op_byte;
    assign sz_half = op_half && !op_byte;
    assign sz_word = !op_byte && !op_half;

    logic        mis;
    logic [3:0]  be;
    logic [31:0] wpat;
    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;

    assign rword = mem[idx];

    always_comb begin
        mis      = 1'b0;
        be       = 4'b0000;
        wpat     = op_wdata;
        load_val = rword;
        unique case (lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        unique case (1'b1)
            sz_byte: begin
                be       = 4'b0001 << lane;
                wpat     = {4{op_wdata[7:0]}};
                load_val = {{24{!op_uns && rbyte[7]}}, rbyte};
            end
            sz_half: begin
                mis      = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wpat     = {2{op_wdata[15:0]}};
                load_val = {{16{!op_uns && rhalf[15]}}, rhalf};
            end
            sz_word: begin
                mis      = (lane != 2'd0);
                be       = 4'b1111;
                wpat     = op_wdata;
                load_val = rword;
            end
            default: begin
                mis = 1'b0;
            end
        endcase
        if (mis) begin
            be = 4'b0000;
        end
    end

    // ------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------
    always_comb begin
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (enter_resp) begin
            rdata_d = mis ? 32'd0 : load_val;
            err_d   = mis;
        end
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------
    // RAM: never cleared; writes blocked while reset is held.
    // ------------------------------------------------------------
    logic wr_en;
    assign wr_en = enter_resp && op_we && CLR;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wpat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states),
// random and directed traffic against a byte-array reference model.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int W0 = 2;
    localparam int W1 = 0;
    localparam int MB = 4 << AW;

    logic clk = 1'b0;
    logic CLR = 1'b1;
    logic [1:0] req, we, byt, half, uns;
    logic [1:0] ready, busy, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .CLR(CLR), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .Byte(byt[0]),
        .Half(half[0]), .UnsignedExt(uns[0]), .ready(ready[0]),
        .rdata(rdata[0]), .busy(busy[0]), .err(err[0])
    );

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .CLR(CLR), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .Byte(byt[1]),
        .Half(half[1]), .UnsignedExt(uns[1]), .ready(ready[1]),
        .rdata(rdata[1]), .busy(busy[1]), .err(err[1])
    );

    typedef struct {
        int          k;
        int          iss;
        int          rdy;
        logic        chk;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [7:0]  bm [2][MB];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] hold [2];
    logic        hold_ok [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int waitc(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: memory as a flat little-endian byte array.
    function automatic void model(
        input int k, input logic w, input logic [31:0] a,
        input logic [31:0] d, input logic b, input logic h,
        input logic u, input logic commit,
        output logic [31:0] rv, output logic e, output logic c);
        int n;
        int base;
        n    = b ? 1 : (h ? 2 : 4);
        base = int'(a & 32'(MB - 1));
        e    = (a & 32'(n - 1)) != 0;
        c    = !w || e;
        rv   = 32'd0;
        if (!e) begin
            if (w) begin
                if (commit)
                    for (int i = 0; i < n; i++)
                        bm[k][base + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++)
                    rv = rv | (32'(bm[k][base + i]) << (8 * i));
                if (!u && n < 4 && rv[8*n-1])
                    rv = rv | ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endfunction

    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic b, input logic h,
                         input logic u, input logic commit);
        logic [31:0] rv;
        logic        e, c;
        exp_t        x;
        model(k, w, a, d, b, h, u, commit, rv, e, c);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        byt[k] = b; half[k] = h; uns[k] = u;
        x.k = k; x.iss = cyc; x.rdy = cyc + waitc(k) + 1;
        x.chk = c; x.data = rv; x.err = e;
        sb.push_back(x);
    endtask

    task automatic scramble(input int k);
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom;
        wdata[k] = $urandom; byt[k] = 1'($urandom);
        half[k] = 1'($urandom); uns[k] = 1'($urandom);
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic b, input logic h,
                      input logic u);
        issue(k, w, a, d, b, h, u, 1'b1);
        @(negedge clk);
        scramble(k);
        wait_ready(k);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        #2 CLR = 1'b0;
        @(negedge clk);
        #2 CLR = 1'b1;
        @(negedge clk);
    endtask

    task automatic rnd_op(input int k);
        int          sz;
        logic [31:0] a;
        sz = $urandom_range(0, 2);
        a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        op(k, 1'($urandom), a, $urandom, sz == 0, sz == 1, 1'($urandom));
    endtask

    // Monitor: pops the scoreboard when a DUT presents ready.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   idx;
            logic bexp;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
                if (idx < 0 && sb[i].k == k) idx = i;
            if (!CLR) begin
                check("reset_ctl", {29'd0, ready[k], busy[k], err[k]}, 32'd0);
                check("reset_rdata", rdata[k], 32'd0);
                hold[k]    = 32'd0;
                hold_ok[k] = 1'b1;
            end else begin
                bexp = idx >= 0 && cyc > sb[idx].iss && cyc < sb[idx].rdy;
                check("busy", 32'(busy[k]), 32'(bexp));
                if (ready[k]) begin
                    if (idx < 0) begin
                        check("spurious_ready", 32'(ready[k]), 32'd0);
                    end else begin
                        check("ready_cycle", cyc, sb[idx].rdy);
                        check("err", 32'(err[k]), 32'(sb[idx].err));
                        if (sb[idx].chk)
                            check("rdata", rdata[k], sb[idx].data);
                        hold[k]    = sb[idx].data;
                        hold_ok[k] = sb[idx].chk;
                        sb.delete(idx);
                    end
                end else begin
                    check("err_idle", 32'(err[k]), 32'd0);
                    if (hold_ok[k])
                        check("rdata_hold", rdata[k], hold[k]);
                    if (idx >= 0 && cyc >= sb[idx].rdy) begin
                        check("missing_ready", 32'(ready[k]), 32'd1);
                        sb.delete(idx);
                    end
                end
            end
        end
        if (!CLR) sb.delete();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold_ok[0] = 1'b0; hold_ok[1] = 1'b0;
        hold[0] = 32'd0; hold[1] = 32'd0;
        req = '0; we = '0; byt = '0; half = '0; uns = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        #1 CLR = 1'b0;
        repeat (2) @(negedge clk);
        #2 CLR = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 16; w++)
                op(k, 1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0);

        // Directed sequence, 2 wait states
        op(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        op(0, 1'b1, 32'h13, 32'h80, 1'b1, 1'b0, 1'b0);
        op(0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 1'b0);
        op(0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1);
        op(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, 1'b0);
        op(0, 1'b1, 32'h11, 32'h1234, 1'b0, 1'b1, 1'b0);
        op(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        op(0, 1'b1, 32'h10 + 32'(MB), 32'h11111111, 1'b0, 1'b0, 1'b0);
        op(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset while waiting: store is lost, no ready
        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        scramble(0);
        pulse_clr();
        repeat (4) @(negedge clk);
        op(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset during RESP: store already committed
        issue(0, 1'b1, 32'h24, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        scramble(0);
        wait_ready(0);
        pulse_clr();
        op(0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0);

        // req held high across three back-to-back loads
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (W0 + 2) @(negedge clk);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (W0 + 2) @(negedge clk);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        scramble(0);
        wait_ready(0);
        @(negedge clk);

        repeat (200) rnd_op(0);

        // Zero wait states
        op(1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        op(1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
        op(1, 1'b0, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1);
        issue(1, 1'b1, 32'h28, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        scramble(1);
        wait_ready(1);
        pulse_clr();
        op(1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0);

        repeat (150) rnd_op(1);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage load/store interface.
- The MEM stage issues load/store requests carrying address, write data and size/extension controls (Byte, Half, UnsignedExt_Mem). This block owns the word-organised data RAM.
- Inserts a configurable number of wait states, then returns a one-cycle ready pulse with extended read data. Pipeline enables (EN3/EN4) are driven from ready/busy.

Parameters:
ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words
WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
CLR  input  1  asynchronous, active-low reset
req  input  1  request valid; sampled only in IDLE
we  input  1  1 = store, 0 = load (MemWrite)
addr  input  32  byte address (ALU result)
wdata  input  32  store data (RD2 path), right-aligned
Byte  input  1  byte access
Half  input  1  halfword access (Byte has priority if both are set)
UnsignedExt  input  1  load zero-extends when 1, sign-extends when 0
ready  output  1  one-cycle response strobe
rdata  output  32  extended load data; valid while ready=1
busy  output  1  request accepted and not yet responded
err  output  1  misaligned access flag; valid while ready=1

Behaviour:
- Reset (CLR=0, asynchronous):
  - state=IDLE; ready=0, rdata=0, busy=0, err=0; wait counter=0.
  - RAM contents are untouched by reset.
  - A store not yet committed is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On req=1: capture we, addr, wdata, Byte, Half, UnsignedExt; set busy=1; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - req=0: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, next state is RESP.
  - Input changes are ignored; only captured values are used.
- Entering RESP (the edge that leaves IDLE or WAIT):
  - The store commits to RAM on this edge.
  - Load data is registered into rdata on this edge.
  - err is computed on this edge.
- RESP (exactly one cycle):
  - ready=1, busy=0.
  - Next state is IDLE; req is not sampled during RESP.
  - Back-to-back requests therefore cost WAIT_CYCLES+2 cycles each.
- Latency: req high in IDLE at cycle 0 gives ready=1 in cycle WAIT_CYCLES+1.
- Outside RESP: ready=0, err=0, and rdata holds its last value.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Lane = addr[1:0], little-endian: byte 0 = bits 7:0.
- Stores: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; word writes all four lanes. Other bytes of the word are unchanged.
- Loads:
  - Byte: selected lane, sign- or zero-extended to 32 bits.
  - Half: selected halfword, sign- or zero-extended to 32 bits.
  - Word: full word; UnsignedExt is ignored.
- Misalignment: Half with addr[0]=1, or word with addr[1:0]!=0:
  - No RAM write.
  - rdata=0, err=1, still with a normal ready pulse.
- Reset in mid-operation:
  - Reset in WAIT: the store is lost and no ready is issued.
  - Reset asserted in RESP: the already-committed store remains in RAM.
- Read-after-write: a load of an address written by the immediately preceding store returns the new data.

Test Plan:
- Reset, then word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 (WAIT_CYCLES=2) -> ready high exactly at cycle 3 after each req, busy high in cycles 1-2, load rdata=0xDEADBEEF, err=0.
- Byte store 0x80 to addr=0x13, then byte load addr=0x13 with UnsignedExt=0 -> rdata=0xFFFFFF80; with UnsignedExt=1 -> 0x00000080; word load addr=0x10 -> 0x80ADBEEF.
- Half load addr=0x12 after the previous step, signed -> 0xFFFF80AD; Half store 0x1234 to addr=0x11 -> err=1 on the ready pulse, rdata=0, word at 0x10 unchanged.
- Word store 0x11111111 to addr=0x10 plus 4·2^ADDR_W -> word at addr=0x10 reads 0x11111111 (wrap-around).
- Store 0xCAFEF00D to addr=0x20 with CLR pulsed low during WAIT -> no ready; outputs reset to 0; word load addr=0x20 returns the old value. Repeat with WAIT_CYCLES=0 -> ready at cycle 1.
- Hold req=1 continuously for 3 requests -> ready pulses at cycles 3, 7 and 11 (period WAIT_CYCLES+2); req during RESP not double-accepted.
